// File: rtl/disp_scan_if.sv
// disp_scan_if: load/data and display-drive bundle for the disp_scan
// 4-digit 7-segment scanner.
//   master : the side that loads digit data and watches the display drive
//   slave  : the scanner itself
interface disp_scan_if;
  logic        load;
  logic [15:0] hex_in;
  logic [3:0]  pt_in;
  logic [3:0]  blk_in;
  logic [3:0]  D;
  logic        point;
  logic        LE;
  logic [3:0]  AN;
  logic        frame_tick;

  modport master (
    output load, hex_in, pt_in, blk_in,
    input  D, point, LE, AN, frame_tick
  );

  modport slave (
    input  load, hex_in, pt_in, blk_in,
    output D, point, LE, AN, frame_tick
  );
endinterface

// File: rtl/disp_scan.sv
// disp_scan: time-multiplexed scanner for a 4-digit 7-segment display.
// It drives an MC14495-style decoder (D, point, LE) and the active-low
// anodes (AN).
// New digit data is first held in pending registers. It is promoted to the
// shadow registers only at a frame boundary, so a frame never mixes old and
// new digits.
// Optional feature macro: LEADING_ZERO_BLANK_EN. When it is defined, leading
// zero digits 3..1 are blanked.
module disp_scan #(
  parameter int SCAN_DIV = 50000,  // clocks per digit, >= 2
  parameter int CNT_W    = 16      // 2**CNT_W >= SCAN_DIV
) (
  input  logic         clk,
  input  logic         rst_n,
  disp_scan_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             step;
  logic             boundary;

  logic [15:0] pend_hex_q, pend_hex_d;
  logic [3:0]  pend_pt_q,  pend_pt_d;
  logic [3:0]  pend_blk_q, pend_blk_d;
  logic        pend_valid_q, pend_valid_d;

  logic [15:0] shad_hex_q, shad_hex_d;
  logic [3:0]  shad_pt_q,  shad_pt_d;
  logic [3:0]  shad_blk_q, shad_blk_d;

  logic [3:0]  eff_blk;
  logic [3:0]  an_q, an_d;
  logic [3:0]  d_q, d_d;
  logic        point_q, point_d;
  logic        le_q, le_d;
  logic        ft_q, ft_d;

  // Prescaler and digit index: a step wraps the prescaler and advances the digit
  always_comb begin
    step     = (cnt_q == CNT_LAST);
    boundary = step && (idx_q == 2'd3);
    if (step) begin
      cnt_d = {CNT_W{1'b0}};
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
  end

  // Pending/shadow update: loads go to pending; shadow is refreshed only at the
  // frame boundary, and a load on the boundary bypasses pending.
  always_comb begin
    pend_hex_d   = pend_hex_q;
    pend_pt_d    = pend_pt_q;
    pend_blk_d   = pend_blk_q;
    pend_valid_d = pend_valid_q;
    shad_hex_d   = shad_hex_q;
    shad_pt_d    = shad_pt_q;
    shad_blk_d   = shad_blk_q;
    if (bus.load) begin
      pend_hex_d   = bus.hex_in;
      pend_pt_d    = bus.pt_in;
      pend_blk_d   = bus.blk_in;
      pend_valid_d = 1'b1;
    end else begin
      pend_valid_d = pend_valid_q;
    end
    if (boundary) begin
      if (bus.load) begin
        shad_hex_d = bus.hex_in;
        shad_pt_d  = bus.pt_in;
        shad_blk_d = bus.blk_in;
      end else if (pend_valid_q) begin
        shad_hex_d = pend_hex_q;
        shad_pt_d  = pend_pt_q;
        shad_blk_d = pend_blk_q;
      end else begin
        shad_hex_d = shad_hex_q;
      end
      pend_valid_d = 1'b0;
    end else begin
      shad_hex_d = shad_hex_d;
    end
  end

  // Effective per-digit blank, with optional leading-zero suppression on digits 3..1
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:1] zero_hi;
    zero_hi[3] = (shad_hex_q[15:12] == 4'd0);
    zero_hi[2] = zero_hi[3] && (shad_hex_q[11:8] == 4'd0);
    zero_hi[1] = zero_hi[2] && (shad_hex_q[7:4] == 4'd0);
    eff_blk    = shad_blk_q | {zero_hi, 1'b0};
`else
    eff_blk    = shad_blk_q;
`endif
  end

  // Display drive for the current digit, taken from the shadow registers
  always_comb begin
    an_d    = ~(4'b0001 << idx_q);
    d_d     = shad_hex_q[{idx_q, 2'b00} +: 4];
    point_d = shad_pt_q[idx_q];
    le_d    = eff_blk[idx_q];
    ft_d    = boundary;
  end

  // State and output registers; reset blanks the display and drops pending data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= {CNT_W{1'b0}};
      idx_q        <= 2'd0;
      pend_hex_q   <= 16'd0;
      pend_pt_q    <= 4'd0;
      pend_blk_q   <= 4'd0;
      pend_valid_q <= 1'b0;
      shad_hex_q   <= 16'd0;
      shad_pt_q    <= 4'd0;
      shad_blk_q   <= 4'b1111;
      an_q         <= 4'b1111;
      d_q          <= 4'd0;
      point_q      <= 1'b0;
      le_q         <= 1'b1;
      ft_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_hex_q   <= pend_hex_d;
      pend_pt_q    <= pend_pt_d;
      pend_blk_q   <= pend_blk_d;
      pend_valid_q <= pend_valid_d;
      shad_hex_q   <= shad_hex_d;
      shad_pt_q    <= shad_pt_d;
      shad_blk_q   <= shad_blk_d;
      an_q         <= an_d;
      d_q          <= d_d;
      point_q      <= point_d;
      le_q         <= le_d;
      ft_q         <= ft_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.D          = d_q;
  assign bus.point      = point_q;
  assign bus.LE         = le_q;
  assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: self-checking bench for disp_scan with SCAN_DIV=4.
// The reference model is written from edge arithmetic on the edge count n
// after reset release:
//   - the digit shown after edge n is ((n-1)/SCAN_DIV) mod 4;
//   - frame boundaries fall on edges where n is a multiple of 4*SCAN_DIV.
module tb_disp_scan;
  localparam int SD = 4;
  localparam int FR = 4 * SD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  disp_scan_if bus ();
  disp_scan #(.SCAN_DIV(SD), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int n        = 0;

  logic [15:0] m_hex, p_hex;
  logic [3:0]  m_pt, m_blk, p_pt, p_blk;
  bit          p_v;
  logic [3:0]  e_an, e_d;
  logic        e_pt, e_le, e_ft;

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  pt;
    logic [3:0]  blk;
    logic [15:0] exp_d;
    logic [3:0]  exp_pt;
    logic [3:0]  exp_le;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
    end
  endtask

  function automatic logic m_le(input int dig);
    logic r;
    r = m_blk[dig];
`ifdef LEADING_ZERO_BLANK_EN
    if (dig != 0 && (m_hex >> (4 * dig)) == 16'd0) r = 1'b1;
`endif
    return r;
  endfunction

  task automatic model_reset();
    n     = 0;
    m_hex = 16'd0; m_pt = 4'd0; m_blk = 4'hF;
    p_hex = 16'd0; p_pt = 4'd0; p_blk = 4'd0; p_v = 1'b0;
  endtask

  // One clock: drive inputs, advance the model on the edge, compare at negedge
  task automatic tick(input bit ld, input logic [15:0] h, input logic [3:0] p,
                      input logic [3:0] b, input bit chk);
    int dig;
    bus.load = ld; bus.hex_in = h; bus.pt_in = p; bus.blk_in = b;
    @(posedge clk);
    n++;
    dig  = ((n - 1) / SD) % 4;
    e_an = ~(4'b0001 << dig);
    e_d  = 4'((m_hex >> (4 * dig)) & 16'h000F);
    e_pt = m_pt[dig];
    e_le = m_le(dig);
    e_ft = ((n % FR) == 0);
    if (ld) begin
      p_hex = h; p_pt = p; p_blk = b; p_v = 1'b1;
    end
    if ((n % FR) == 0 && p_v) begin
      m_hex = p_hex; m_pt = p_pt; m_blk = p_blk; p_v = 1'b0;
    end
    @(negedge clk);
    bus.load = 1'b0;
    if (chk) begin
      check("AN", 16'(bus.AN), 16'(e_an));
      check("D", 16'(bus.D), 16'(e_d));
      check("point", 16'(bus.point), 16'(e_pt));
      check("LE", 16'(bus.LE), 16'(e_le));
      check("frame_tick", 16'(bus.frame_tick), 16'(e_ft));
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 16'd0, 4'd0, 4'd0, 1'b1);
  endtask

  task automatic idle_until(input int phase);
    for (int i = 0; i < FR && (n % FR) != phase; i++) tick(1'b0, 16'd0, 4'd0, 4'd0, 1'b1);
  endtask

  // Check one full frame (starting at a boundary) against constant expectations
  task automatic check_frame(input string name, input logic [15:0] ed,
                             input logic [3:0] ep, input logic [3:0] el);
    int dig;
    for (int i = 0; i < FR; i++) begin
      tick(1'b0, 16'd0, 4'd0, 4'd0, 1'b1);
      if (((n - 1) % SD) == 0) begin
        dig = ((n - 1) / SD) % 4;
        check({name, "_D"}, 16'(bus.D), 16'(ed[4 * dig +: 4]));
        check({name, "_pt"}, 16'(bus.point), 16'(ep[dig]));
        check({name, "_LE"}, 16'(bus.LE), 16'(el[dig]));
      end
    end
  endtask

  initial begin
    vecs[0] = '{16'h1A3F, 4'b0100, 4'b0000, 16'h1A3F, 4'b0100, 4'b0000};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[1] = '{16'h0040, 4'b0000, 4'b0000, 16'h0040, 4'b0000, 4'b1100};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b1110};
    vecs[4] = '{16'h0305, 4'b0001, 4'b0001, 16'h0305, 4'b0001, 4'b1001};
`else
    vecs[1] = '{16'h0040, 4'b0000, 4'b0000, 16'h0040, 4'b0000, 4'b0000};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0000};
    vecs[4] = '{16'h0305, 4'b0001, 4'b0001, 16'h0305, 4'b0001, 4'b0001};
`endif
    vecs[3] = '{16'h9876, 4'b1111, 4'b1010, 16'h9876, 4'b1111, 4'b1010};

    bus.load = 1'b0; bus.hex_in = 16'd0; bus.pt_in = 4'd0; bus.blk_in = 4'd0;
    model_reset();

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_AN", 16'(bus.AN), 16'h000F);
    check("rst_LE", 16'(bus.LE), 16'h0001);
    check("rst_D", 16'(bus.D), 16'h0000);
    check("rst_point", 16'(bus.point), 16'h0000);
    check("rst_ft", 16'(bus.frame_tick), 16'h0000);
    rst_n = 1'b1;

    // First edge after release shows digit 0; free scanning over two frames
    tick(1'b0, 16'd0, 4'd0, 4'd0, 1'b0);
    check("first_AN", 16'(bus.AN), 16'h000E);
    check("first_LE", 16'(bus.LE), 16'h0001);
    idle(2 * FR + 7);

    // Table vectors: load mid-frame, hold through the boundary, check new frame
    for (int v = 0; v < 5; v++) begin
      idle_until(6);
      tick(1'b1, vecs[v].hex, vecs[v].pt, vecs[v].blk, 1'b1);
      idle_until(0);
      check_frame("tbl", vecs[v].exp_d, vecs[v].exp_pt, vecs[v].exp_le);
    end

    // Two loads in one frame: the last one wins
    idle_until(2);
    tick(1'b1, 16'h1111, 4'd0, 4'd0, 1'b1);
    idle_until(8);
    tick(1'b1, 16'h2222, 4'd0, 4'd0, 1'b1);
    idle_until(0);
    check_frame("last_wins", 16'h2222, 4'd0, 4'd0);

    // Load on the exact boundary edge bypasses pending into this frame
    idle_until(FR - 1);
    tick(1'b1, 16'h5555, 4'b1001, 4'd0, 1'b1);
    check_frame("bypass", 16'h5555, 4'b1001, 4'd0);

    // Randomized loads against the model
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), 4'($urandom), 1'b1);
    end

    // Mid-frame reset while digit 2 is shown, with pending data in flight
    idle_until(2);
    tick(1'b1, 16'hBEEF, 4'hF, 4'h0, 1'b1);
    idle_until(9);
    check("pre_rst_AN", 16'(bus.AN), 16'h000B);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_AN", 16'(bus.AN), 16'h000F);
    check("async_LE", 16'(bus.LE), 16'h0001);
    check("async_D", 16'(bus.D), 16'h0000);
    check("async_ft", 16'(bus.frame_tick), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_frame("post_rst", 16'h0000, 4'd0, 4'hF);
    check_frame("post_rst2", 16'h0000, 4'd0, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/disp_scan.md
Name: disp_scan

Overview:
Time-multiplexed scanner for a 4-digit 7-segment display. Sits directly upstream of the MC14495-style hex-to-7-segment decoder and drives its D3..D0, point and LE inputs, plus the active-low anode select for the display. A frame-synchronous shadow register makes new display values appear only at frame boundaries, so no digit ever shows a partial update.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays active; legal range ≥2.
CNT_W, 16, prescaler counter width; must satisfy 2^CNT_W ≥ SCAN_DIV.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
load  input  1  single-cycle strobe; captures hex_in, pt_in and blk_in.
hex_in  input  16  four hex digits; [3:0] is digit 0, rightmost.
pt_in  input  4  decimal point per digit, 1 = lit.
blk_in  input  4  per-digit blank request, 1 = blank.
D  output  4  hex value of the active digit, to decoder {D3,D2,D1,D0}.
point  output  1  decimal point of the active digit, to decoder point.
LE  output  1  decoder blank/latch enable, 1 = blank.
AN  output  4  anode select, active-low, one-hot-zero while scanning.
frame_tick  output  1  one-cycle pulse when digit 3 hands over to digit 0.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All outputs are registered.
- Reset values:
  - AN=4'b1111, D=0, point=0, LE=1, frame_tick=0.
  - Prescaler=0, digit index=0.
  - Pending and shadow registers = 0, with blk=4'b1111.
  - pend_valid=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - The cycle at which it equals SCAN_DIV-1 is a "step"; the counter wraps to 0 on that cycle.
- Digit index:
  - Two bits, advances on each step: 0→1→2→3→0.
  - The transition 3→0 is the "frame boundary".
- Output registers, updated every cycle from the current index i and the shadow registers:
  - AN = ~(1<<i).
  - D = shadow_hex[4i+3:4i].
  - point = shadow_pt[i].
  - LE = shadow_blk[i].
- First active output: the first rising edge after rst_n deasserts gives AN=4'b1110 with digit-0 shadow values (all blank).
- Load:
  - On load=1, hex_in, pt_in and blk_in are written into the pending registers and pend_valid is set.
  - Loads are always accepted; if several loads occur within one frame, the last one wins.
- Frame boundary:
  - If pend_valid=1, shadow ← pending and pend_valid is cleared.
  - frame_tick=1 for exactly that one cycle. It is registered, so it rises one cycle after the step that wraps the index.
- Simultaneous load and boundary: the incoming data bypasses pending straight into shadow, and pend_valid ends cleared.
- Digit 0 of a new frame always shows the new shadow contents; digits 1-3 never mix old and new values within a frame.
- Reset mid-frame: everything returns to reset values immediately; pending data is lost.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - The effective blank for digit i (i = 1..3) is shadow_blk[i] OR (digit i and every higher digit are 0 in shadow_hex).
  - Digit 0 follows shadow_blk[0] only.
  - Points still display on blanked digits. The LE output is the effective blank.
- Undefined: LE = shadow_blk[i] with no zero suppression.

Test Plan:
1. SCAN_DIV=4, reset low for 3 cycles and then released → AN=1111, LE=1 during reset. After release AN cycles 1110,1101,1011,0111 with each value held for 4 clocks; frame_tick pulses every 16 clocks.
2. load with hex_in=16'h1A3F, pt_in=4'b0100, blk_in=0 mid-frame → values unchanged until the next boundary. The frame after that shows D=F,3,A,1 on AN 1110,1101,1011,0111, with point=1 only on digit 2.
3. Two loads in one frame, 16'h1111 then 16'h2222 → the next frame shows only 2s. A load on the exact boundary cycle with 16'h5555 → shows 5s in that same frame.
4. rst_n dropped while AN=1011 → on the same edge AN=1111, LE=1, D=0, without waiting for clk. After release, scanning restarts at digit 0 with blank shadow.
5. With LEADING_ZERO_BLANK_EN, load 16'h0040, blk_in=0 → LE=1 on digits 3 and 2, LE=0 on digit 1 (D=4) and digit 0 (D=0). Load 16'h0000 → only digit 0 is lit.
6. Without LEADING_ZERO_BLANK_EN, repeat case 5 → LE=0 on all four digits, D=0,4,0,0.
